// File: rtl/mem_pipe_responder_pkg.sv
// Shared memory-interface package (mem_pkg): word width, default latency and
// depth, request classification, and the byte-address to word-index helper.
// Imported by the responder, its interface, and the cache-side logic.
package mem_pkg;

    localparam int WORD_W                 = 16;
    localparam int ADDR_W                 = 16;
    localparam int MEM_LATENCY_DEFAULT    = 4;
    localparam int MEM_DEPTH_LOG2_DEFAULT = 15;
    localparam int PENDING_W              = 4;

    // Classification of the request presented in a cycle.
    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2,
        REQ_DROP  = 2'd3
    } req_kind_e;

    // Byte address to 16-bit word index. Bit 0 selects a byte within the word
    // and is discarded here. Callers keep only as many low bits as the array
    // is deep, so higher address bits wrap.
    function automatic logic [ADDR_W-2:0] word_index(input logic [ADDR_W-1:0] addr);
        return (ADDR_W-1)'(addr >> 1);
    endfunction

endpackage : mem_pkg

// File: rtl/mem_pipe_responder_if.sv
// Request/response bundle between the arbitrated cache port (master) and the
// memory responder (slave). err_misaligned exists only when ALIGN_CHECK_EN
// is defined.
interface mem_pipe_responder_if;
    import mem_pkg::*;

    logic                 enable;
    logic                 wr;
    logic [ADDR_W-1:0]    addr;
    logic [WORD_W-1:0]    data_in;
    logic [WORD_W-1:0]    data_out;
    logic                 data_valid;
    logic [PENDING_W-1:0] pending;
`ifdef ALIGN_CHECK_EN
    logic                 err_misaligned;
`endif

    modport master (
        output enable, wr, addr, data_in,
`ifdef ALIGN_CHECK_EN
        input  err_misaligned,
`endif
        input  data_out, data_valid, pending
    );

    modport slave (
        input  enable, wr, addr, data_in,
`ifdef ALIGN_CHECK_EN
        output err_misaligned,
`endif
        output data_out, data_valid, pending
    );

endinterface : mem_pipe_responder_if

// File: rtl/mem_pipe_responder_chk.sv
// Protocol checker for mem_pipe_responder outputs: the in-flight read count
// never exceeds the pipeline depth, and a read strobe always corresponds to
// an outstanding read.
module mem_pipe_responder_chk
    import mem_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    input logic [PENDING_W-1:0] pending,
    input logic                 data_valid
);

    a_pending_bound: assert property (
        @(posedge clk) disable iff (rst) pending <= PENDING_W'(LATENCY)
    );

    a_strobe_has_pending: assert property (
        @(posedge clk) disable iff (rst) data_valid |-> (pending != 4'd0)
    );

endmodule : mem_pipe_responder_chk

// File: rtl/mem_pipe_responder_delay_line.sv
// mem_delay_line: LATENCY-stage valid+data shift register with synchronous
// clear. A data stage only loads when the stage before it holds a valid
// entry, so the final data register keeps the last returned word while no
// strobe is present.
module mem_delay_line #(
    parameter int LATENCY = 4,
    parameter int WORD_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data
);

    logic [LATENCY-1:0] valid_r;
    logic [WORD_W-1:0]  data_r [LATENCY];

    // Advance the valid/data line one stage per clock; clear discards all entries.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i] <= {WORD_W{1'b0}};
            end
        end else begin
            valid_r[0] <= in_valid;
            if (in_valid) begin
                data_r[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                if (valid_r[i-1]) begin
                    data_r[i] <= data_r[i-1];
                end
            end
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out_data  = data_r[LATENCY-1];

endmodule : mem_delay_line

// File: rtl/mem_pipe_responder.sv
// mem_pipe_responder: memory-side target of the arbitrated cache port.
// One request per cycle, no backpressure. Reads return after exactly LATENCY
// cycles with a one-cycle data_valid strobe; writes are silent.
// Optional macro ALIGN_CHECK_EN: odd byte addresses are dropped and flagged
// on err_misaligned one cycle later; otherwise addr[0] is ignored.
module mem_pipe_responder
    import mem_pkg::*;
#(
    parameter int LATENCY    = MEM_LATENCY_DEFAULT,
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_pipe_responder_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Storage is intentionally not reset; contents come from the simulation load.
    logic [WORD_W-1:0]     mem_r [DEPTH];

    logic [ADDR_W-2:0]     word_full_s;
    logic [DEPTH_LOG2-1:0] word_idx_s;
    logic                  misaligned_s;
    req_kind_e             req_kind_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic [WORD_W-1:0]     rd_word_s;
    logic                  dl_valid_s;
    logic [WORD_W-1:0]     dl_data_s;
    logic [PENDING_W-1:0]  pending_r;

    // Decode the presented request into idle/read/write/drop.
    always_comb begin
        word_full_s  = word_index(bus.addr);
        word_idx_s   = word_full_s[DEPTH_LOG2-1:0];
`ifdef ALIGN_CHECK_EN
        misaligned_s = bus.addr[0];
`else
        misaligned_s = 1'b0;
`endif
        req_kind_s   = REQ_IDLE;
        if (rst || !bus.enable) begin
            req_kind_s = REQ_IDLE;
        end else if (misaligned_s) begin
            req_kind_s = REQ_DROP;
        end else if (bus.wr) begin
            req_kind_s = REQ_WRITE;
        end else begin
            req_kind_s = REQ_READ;
        end
    end

    // Map the request kind onto array write and read-enqueue strobes.
    always_comb begin
        wr_accept_s = 1'b0;
        rd_accept_s = 1'b0;
        case (req_kind_s)
            REQ_WRITE: wr_accept_s = 1'b1;
            REQ_READ:  rd_accept_s = 1'b1;
            default: begin
                wr_accept_s = 1'b0;
                rd_accept_s = 1'b0;
            end
        endcase
    end

    // Commit accepted writes into the array at the acceptance edge.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[word_idx_s] <= bus.data_in;
        end
    end

    // The word is captured into the first pipeline stage at the acceptance
    // edge, so a later write to the same word cannot change an in-flight read.
    assign rd_word_s = mem_r[word_idx_s];

    mem_delay_line #(
        .LATENCY (LATENCY),
        .WORD_W  (WORD_W)
    ) u_delay_line (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (rd_accept_s),
        .in_data   (rd_word_s),
        .out_valid (dl_valid_s),
        .out_data  (dl_data_s)
    );

    // Track reads accepted but not yet strobed back.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 4'd0;
        end else begin
            case ({rd_accept_s, dl_valid_s})
                2'b10:   pending_r <= pending_r + 4'd1;
                2'b01:   pending_r <= pending_r - 4'd1;
                default: pending_r <= pending_r;
            endcase
        end
    end

`ifdef ALIGN_CHECK_EN
    logic err_misaligned_r;

    // Flag a dropped odd-address request in the cycle after it was presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_misaligned_r <= 1'b0;
        end else begin
            err_misaligned_r <= (req_kind_s == REQ_DROP);
        end
    end

    assign bus.err_misaligned = err_misaligned_r;
`endif

    assign bus.data_out   = dl_data_s;
    assign bus.data_valid = dl_valid_s;
    assign bus.pending    = pending_r;

endmodule : mem_pipe_responder

// File: tb/tb_mem_pipe_responder.sv
// Self-checking bench for mem_pipe_responder. DUT A uses the default
// parameters and is driven from a vector table with a scoreboard queue;
// DUT B (LATENCY=1, DEPTH_LOG2=4) exercises the short pipeline and address wrap.
`timescale 1ns/1ps
module tb_mem_pipe_responder;
    import mem_pkg::*;

    localparam int LAT_A = 4;
    localparam int DEP_A = 15;
    localparam int LAT_B = 1;
    localparam int DEP_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    mem_pipe_responder_if bus_a ();
    mem_pipe_responder_if bus_b ();

    mem_pipe_responder #(.LATENCY(LAT_A), .DEPTH_LOG2(DEP_A)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    mem_pipe_responder #(.LATENCY(LAT_B), .DEPTH_LOG2(DEP_B)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    mem_pipe_responder_chk #(.LATENCY(LAT_A)) chk_a (.clk(clk), .rst(rst_a), .pending(bus_a.pending), .data_valid(bus_a.data_valid));
    mem_pipe_responder_chk #(.LATENCY(LAT_B)) chk_b (.clk(clk), .rst(rst_b), .pending(bus_b.pending), .data_valid(bus_b.data_valid));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mis_cyc  = -10;
    bit mon_on   = 1'b0;

    typedef struct {
        logic [15:0] data;
        int          acc;
        int          due;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t tbl[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic add_vec(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] d, input logic [15:0] ex);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = a; v.wdata = d; v.exp_rd = ex;
        tbl.push_back(v);
    endtask

    // Present one request to DUT A for one cycle; reads queue their expected word.
    task automatic drive_a(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] d, input logic [15:0] ex);
        logic drop;
        drop = 1'b0;
`ifdef ALIGN_CHECK_EN
        drop = a[0];
        if (en && a[0]) mis_cyc = cyc;
`endif
        bus_a.enable = en; bus_a.wr = wr; bus_a.addr = a; bus_a.data_in = d;
        if (en && !wr && !drop) q.push_back('{ex, cyc, cyc + LAT_A});
        @(posedge clk); #1;
        bus_a.enable = 1'b0;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) drive_a(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    endtask

    // One-cycle reset of DUT A; in-flight reads are forgotten once it is sampled.
    task automatic reset_a();
        rst_a = 1'b1;
        bus_a.enable = 1'b0;
        @(posedge clk); #1;
        q.delete();
        rst_a = 1'b0;
    endtask

    // One cycle on DUT B with the outputs expected in that same cycle.
    task automatic step_b(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input logic ev, input logic [15:0] ed, input logic [3:0] ep);
        bus_b.enable = en; bus_b.wr = wr; bus_b.addr = a; bus_b.data_in = d;
        @(negedge clk);
        chk("b_data_valid", {31'd0, bus_b.data_valid}, {31'd0, ev});
        if (ev) chk("b_data_out", {16'd0, bus_b.data_out}, {16'd0, ed});
        chk("b_pending", {28'd0, bus_b.pending}, {28'd0, ep});
        @(posedge clk); #1;
        bus_b.enable = 1'b0;
    endtask

    // Scoreboard for DUT A: strobe timing/data, in-flight count, error pulse.
    always @(negedge clk) begin
        if (mon_on) begin
            int  pend_exp;
            logic exp_v;
            pend_exp = 0;
            foreach (q[i]) if (q[i].acc < cyc) pend_exp++;
            chk("a_pending", {28'd0, bus_a.pending}, pend_exp);
            exp_v = (q.size() != 0) && (q[0].due == cyc);
            chk("a_data_valid", {31'd0, bus_a.data_valid}, {31'd0, exp_v});
            if (exp_v) begin
                if (bus_a.data_valid === 1'b1) chk("a_data_out", {16'd0, bus_a.data_out}, {16'd0, q[0].data});
                void'(q.pop_front());
            end
`ifdef ALIGN_CHECK_EN
            chk("a_err_misaligned", {31'd0, bus_a.err_misaligned}, {31'd0, (cyc == mis_cyc + 1)});
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] rd_0010;
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.enable = 1'b0; bus_a.wr = 1'b0; bus_a.addr = 16'h0000; bus_a.data_in = 16'h0000;
        bus_b.enable = 1'b0; bus_b.wr = 1'b0; bus_b.addr = 16'h0000; bus_b.data_in = 16'h0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_data_out",   {16'd0, bus_a.data_out}, 32'd0);
        chk("rst_a_data_valid", {31'd0, bus_a.data_valid}, 32'd0);
        chk("rst_a_pending",    {28'd0, bus_a.pending}, 32'd0);
        chk("rst_b_data_out",   {16'd0, bus_b.data_out}, 32'd0);
        chk("rst_b_data_valid", {31'd0, bus_b.data_valid}, 32'd0);
        chk("rst_b_pending",    {28'd0, bus_b.pending}, 32'd0);
`ifdef ALIGN_CHECK_EN
        chk("rst_a_err", {31'd0, bus_a.err_misaligned}, 32'd0);
`endif
        @(posedge clk); #1;
        rst_a  = 1'b0;
        mon_on = 1'b1;

`ifdef ALIGN_CHECK_EN
        rd_0010 = 16'hBEEF;
`else
        rd_0010 = 16'h1234;
`endif
        // Preload, then write-then-read of the same word.
        add_vec(1'b1, 1'b1, 16'h0000, 16'h1111, 16'h0000);
        add_vec(1'b1, 1'b1, 16'h0002, 16'h2222, 16'h0000);
        add_vec(1'b1, 1'b1, 16'h0004, 16'h3333, 16'h0000);
        add_vec(1'b1, 1'b1, 16'h0006, 16'h4444, 16'h0000);
        add_vec(1'b1, 1'b1, 16'h0020, 16'h0001, 16'h0000);
        add_vec(1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        add_vec(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        for (int i = 0; i < 5; i++) add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        // Burst of four back-to-back reads; pending peaks at four.
        add_vec(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111);
        add_vec(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2222);
        add_vec(1'b1, 1'b0, 16'h0004, 16'h0000, 16'h3333);
        add_vec(1'b1, 1'b0, 16'h0006, 16'h0000, 16'h4444);
        for (int i = 0; i < 4; i++) add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        // Read/write race: the in-flight read keeps the old word.
        add_vec(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0001);
        add_vec(1'b1, 1'b1, 16'h0020, 16'h00FF, 16'h0000);
        add_vec(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h00FF);
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        // Odd byte address: ignored bit 0, or dropped with the alignment check.
        add_vec(1'b1, 1'b1, 16'h0011, 16'h1234, 16'h0000);
        add_vec(1'b1, 1'b0, 16'h0010, 16'h0000, rd_0010);
        add_vec(1'b1, 1'b0, 16'h0011, 16'h0000, rd_0010);
        // Top of the address space.
        add_vec(1'b1, 1'b1, 16'hFFFE, 16'hCAFE, 16'h0000);
        add_vec(1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'hCAFE);
        for (int i = 0; i < 6; i++) add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

        foreach (tbl[i]) drive_a(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
        chk("a_queue_drained_table", q.size(), 32'd0);

        // Reset mid-flight: two reads discarded, committed writes survive.
        drive_a(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111);
        drive_a(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2222);
        reset_a();
        idle_a(6);
        drive_a(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2222);
        idle_a(LAT_A + 2);
        chk("a_queue_drained_reset", q.size(), 32'd0);

        // DUT B: single-cycle latency and wrap of bits above DEPTH_LOG2.
        rst_b = 1'b0;
        step_b(1'b1, 1'b1, 16'h0004, 16'hA5A5, 1'b0, 16'h0000, 4'd0);
        step_b(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h0000, 4'd0);
        step_b(1'b1, 1'b1, 16'h0024, 16'h5A5A, 1'b1, 16'hA5A5, 4'd1);
        step_b(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h0000, 4'd0);
        step_b(1'b1, 1'b0, 16'h0024, 16'h0000, 1'b1, 16'h5A5A, 4'd1);
        step_b(1'b1, 1'b0, 16'h8004, 16'h0000, 1'b1, 16'h5A5A, 4'd1);
        step_b(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, 4'd1);
        step_b(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'd0);

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_pipe_responder
